// File: rtl/delay_step_seq_pkg.sv
// Shared types and width helper for the delay/step sequencer.
package delay_step_seq_pkg;

    typedef enum logic {
        MODE_SEQ = 1'b0,
        MODE_PAR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Elapsed/target width: wide enough that a SEQ sum of all delays cannot overflow.
    function automatic int t_width(input int num_steps, input int delay_w);
        return delay_w + $clog2(num_steps) + 1;
    endfunction

endpackage

// File: rtl/delay_step_sequencer_if.sv
// Config/control/result bundle for delay_step_sequencer.
// DELAY_STEP_SEQ_TSTAMP_EN adds the per-step step_time capture bus.
interface delay_step_sequencer_if #(
    parameter int NUM_STEPS = 4,
    parameter int DELAY_W   = 8,
    parameter int DATA_W    = 2
);
    localparam int IDX_W = $clog2(NUM_STEPS);

    logic                        cfg_we;
    logic [IDX_W-1:0]            cfg_idx;
    logic [DELAY_W-1:0]          cfg_delay;
    logic [DATA_W-1:0]           cfg_data;
    logic                        start;
    logic                        mode;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic [NUM_STEPS-1:0]        step_fire;
    logic [NUM_STEPS-1:0]        fired;
    logic [NUM_STEPS*DATA_W-1:0] out_data;
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
    localparam int T_W = delay_step_seq_pkg::t_width(NUM_STEPS, DELAY_W);
    logic [NUM_STEPS*T_W-1:0]    step_time;
`endif

    modport master (
        output cfg_we, cfg_idx, cfg_delay, cfg_data, start, mode, abort,
        input  busy, done, step_fire, fired, out_data
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
        , input step_time
`endif
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_delay, cfg_data, start, mode, abort,
        output busy, done, step_fire, fired, out_data
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
        , output step_time
`endif
    );

endinterface

// File: rtl/delay_step_prefix_sum.sv
// Combinational fire-target generator: running sum of delays (SEQ) or the
// delays themselves zero-extended (PAR).
module delay_step_prefix_sum
    import delay_step_seq_pkg::*;
#(
    parameter  int NUM_STEPS = 4,
    parameter  int DELAY_W   = 8,
    localparam int T_W       = t_width(NUM_STEPS, DELAY_W)
) (
    input  logic [NUM_STEPS*DELAY_W-1:0] delays,
    input  mode_e                        mode,
    output logic [NUM_STEPS*T_W-1:0]     targets
);

    logic [T_W-1:0] acc;

    always_comb begin
        acc     = '0;
        targets = '0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            acc = acc + T_W'(delays[k*DELAY_W +: DELAY_W]);
            targets[k*T_W +: T_W] = (mode == MODE_PAR) ? T_W'(delays[k*DELAY_W +: DELAY_W]) : acc;
        end
    end

endmodule

// File: rtl/delay_step_sequencer.sv
// Timed-step engine: applies NUM_STEPS programmed values at programmed offsets
// (SEQ or PAR per run). Optional step_time capture under DELAY_STEP_SEQ_TSTAMP_EN.
module delay_step_sequencer
    import delay_step_seq_pkg::*;
#(
    parameter int NUM_STEPS = 4,
    parameter int DELAY_W   = 8,
    parameter int DATA_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    delay_step_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam int T_W   = t_width(NUM_STEPS, DELAY_W);

    state_e                      state_reg, state_next;
    logic [T_W-1:0]              elapsed_reg;
    logic [NUM_STEPS*T_W-1:0]    target_reg, target_next;
    logic [NUM_STEPS-1:0]        fired_reg, step_fire_reg, fire_vec;
    logic [NUM_STEPS*DATA_W-1:0] out_data_reg;
    logic [NUM_STEPS*DELAY_W-1:0] delay_mem;
    logic [NUM_STEPS*DATA_W-1:0] data_mem;
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
    logic [NUM_STEPS*T_W-1:0]    step_time_reg;
`endif

    delay_step_prefix_sum #(
        .NUM_STEPS (NUM_STEPS),
        .DELAY_W   (DELAY_W)
    ) u_prefix_sum (
        .delays  (delay_mem),
        .mode    (mode_e'(bus.mode)),
        .targets (target_next)
    );

    // A step fires once, on the edge where elapsed equals its latched target.
    generate
        for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_fire
            assign fire_vec[gi] = (state_reg == RUN) && !fired_reg[gi] &&
                                  (elapsed_reg == target_reg[gi*T_W +: T_W]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.abort)                       state_next = IDLE;
                else if (&(fired_reg | fire_vec))    state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elapsed_reg   <= '0;
            target_reg    <= '0;
            fired_reg     <= '0;
            step_fire_reg <= '0;
            out_data_reg  <= '0;
            delay_mem     <= '0;
            data_mem      <= '0;
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
            step_time_reg <= '0;
`endif
        end else begin
            step_fire_reg <= fire_vec;
            if (state_reg == IDLE) begin
                // Index compare per slot drops out-of-range cfg_idx naturally.
                if (bus.cfg_we) begin
                    for (int k = 0; k < NUM_STEPS; k++) begin
                        if (bus.cfg_idx == IDX_W'(k)) begin
                            delay_mem[k*DELAY_W +: DELAY_W] <= bus.cfg_delay;
                            data_mem[k*DATA_W +: DATA_W]    <= bus.cfg_data;
                        end
                    end
                end
                if (bus.start) begin
                    target_reg  <= target_next;
                    elapsed_reg <= '0;
                    fired_reg   <= '0;
                end
            end
            // Fires still land on an abort edge; only the FSM ignores them.
            if (state_reg == RUN) begin
                elapsed_reg <= elapsed_reg + T_W'(1);
                fired_reg   <= fired_reg | fire_vec;
                for (int k = 0; k < NUM_STEPS; k++) begin
                    if (fire_vec[k]) begin
                        out_data_reg[k*DATA_W +: DATA_W] <= data_mem[k*DATA_W +: DATA_W];
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
                        step_time_reg[k*T_W +: T_W] <= elapsed_reg + T_W'(1);
`endif
                    end
                end
            end
        end
    end

    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == FIN);
    assign bus.step_fire = step_fire_reg;
    assign bus.fired     = fired_reg;
    assign bus.out_data  = out_data_reg;
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
    assign bus.step_time = step_time_reg;
`endif

endmodule

// File: tb/tb_delay_step_sequencer.sv
// Scoreboard bench for delay_step_sequencer: expected fire events are queued at
// start and matched against step_fire/done as they appear.
module tb_delay_step_sequencer;
    localparam int NS  = 4;
    localparam int DW  = 8;
    localparam int DAW = 2;
    localparam int TW  = DW + $clog2(NS) + 1;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic       done;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  exp_q[$];

    logic [7:0]    m_delay [NS];
    logic [1:0]    m_data  [NS];
    logic [7:0]    m_out;
    logic [NS*TW-1:0] m_ts;

    delay_step_sequencer_if #(.NUM_STEPS(NS), .DELAY_W(DW), .DATA_W(DAW)) bus ();

    delay_step_sequencer #(.NUM_STEPS(NS), .DELAY_W(DW), .DATA_W(DAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (bus.step_fire != '0 || bus.done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {bus.done, bus.step_fire}, 0);
            end else begin
                e = exp_q.pop_front();
                check("fire_cycle", cyc, e.cyc);
                check("fire_mask", bus.step_fire, e.mask);
                check("done", bus.done, e.done);
                check("out_data", bus.out_data, e.data);
                if (e.done) begin
                    check("done_busy", bus.busy, 0);
                    check("done_fired", bus.fired, 4'hF);
                end
                $display("event cyc=%0d mask=%b done=%b out_data=%h", cyc, bus.step_fire, bus.done, bus.out_data);
            end
        end
    end

    task automatic cfg_all(input logic [31:0] dl, input logic [7:0] vl);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            bus.cfg_we    = 1'b1;
            bus.cfg_idx   = 2'(k);
            bus.cfg_delay = dl[k*8 +: 8];
            bus.cfg_data  = vl[k*2 +: 2];
            m_delay[k]    = dl[k*8 +: 8];
            m_data[k]     = vl[k*2 +: 2];
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // cut_at: abort (or reset when use_rst) observed at edge E0+cut_at; 0 = full run.
    task automatic run(input bit par, input int cut_at, input bit use_rst, input bit poke);
        int t[NS];
        int acc, tmax, c0, n;
        logic [3:0] mask, exp_fired;
        acc = 0; tmax = 0; exp_fired = '0;
        for (int k = 0; k < NS; k++) begin
            acc += int'(m_delay[k]);
            t[k] = par ? int'(m_delay[k]) : acc;
            if (t[k] > tmax) tmax = t[k];
        end
        @(negedge clk);
        c0 = cyc + 1;
        for (int o = 1; o <= tmax + 1; o++) begin
            mask = '0;
            for (int k = 0; k < NS; k++) if (t[k] + 1 == o) mask[k] = 1'b1;
            if (mask != '0 && (cut_at == 0 || o <= cut_at)) begin
                for (int k = 0; k < NS; k++) if (mask[k]) begin
                    m_out[k*2 +: 2] = m_data[k];
                    m_ts[k*TW +: TW] = TW'(o);
                end
                exp_fired |= mask;
                exp_q.push_back('{c0 + o, mask, (cut_at == 0 && o == tmax + 1), m_out});
            end
        end
        bus.start = 1'b1;
        bus.mode  = par;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke) begin
            bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_delay = 8'd9; bus.cfg_data = 2'd3;
            bus.start = 1'b1; bus.mode = ~par;
            @(negedge clk);
            bus.cfg_we = 1'b0; bus.start = 1'b0;
            check("poke_busy", bus.busy, 1);
        end
        if (cut_at != 0 && !use_rst) begin
            while (cyc < c0 + cut_at - 1) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check("abort_busy", bus.busy, 0);
            check("abort_fired", bus.fired, exp_fired);
            check("abort_out_data", bus.out_data, m_out);
        end else if (use_rst) begin
            while (cyc < c0 + cut_at) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("rst_busy", bus.busy, 0);
            check("rst_fired", bus.fired, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_step_fire", bus.step_fire, 0);
            exp_q.delete();
            m_out = '0; m_ts = '0;
            for (int k = 0; k < NS; k++) begin m_delay[k] = '0; m_data[k] = '0; end
            @(negedge clk);
            rst = 1'b0;
        end else begin
            n = 0;
            while (exp_q.size() != 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                check("timeout_pending", exp_q.size(), 0);
                exp_q.delete();
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_delay = '0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0;
        m_out = '0; m_ts = '0;
        for (int k = 0; k < NS; k++) begin m_delay[k] = '0; m_data[k] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_fired", bus.fired, 0);
        check("reset_step_fire", bus.step_fire, 0);
        check("reset_out_data", bus.out_data, 0);
        rst = 1'b0;

        cfg_all({8'd20, 8'd10, 8'd5, 8'd0}, {2'b10, 2'b01, 2'b01, 2'b00});
        run(1'b1, 0, 1'b0, 1'b1);
        check("par_out_data", bus.out_data, 8'b10_01_01_00);
`ifdef DELAY_STEP_SEQ_TSTAMP_EN
        check("par_step_time", bus.step_time, m_ts);
`endif
        run(1'b0, 0, 1'b0, 1'b0);

        cfg_all({8'd7, 8'd3, 8'd3, 8'd3}, {2'b10, 2'b01, 2'b01, 2'b00});
        run(1'b1, 0, 1'b0, 1'b0);

        cfg_all({8'd20, 8'd10, 8'd5, 8'd0}, {2'd3, 2'd0, 2'd2, 2'd1});
        run(1'b0, 10, 1'b0, 1'b0);
        check("abort_slots_kept", bus.out_data[7:4], 4'b10_01);
        run(1'b1, 0, 1'b0, 1'b0);

        cfg_all({8'd20, 8'd10, 8'd5, 8'd0}, {2'd1, 2'd2, 2'd3, 2'd1});
        run(1'b0, 7, 1'b1, 1'b0);
        run(1'b0, 0, 1'b0, 1'b0);

        check("final_busy", bus.busy, 0);
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delay_step_sequencer.md
Name: delay_step_sequencer

Overview:
- Synthesizable, parametrised timed-step engine. Each run applies NUM_STEPS programmed data values to output registers at programmed cycle offsets.
- Run mode is selectable per run:
  - SEQ (begin-end semantics): each delay counts from the previous step.
  - PAR (fork-join semantics): each delay counts from start.
- Used as a stimulus and timing generator in the block-level test harnesses. Replaces hand-written delay blocks.

Parameters:
- NUM_STEPS, 4, number of steps/output slots (>=2)
- DELAY_W, 8, width of each per-step delay in clock cycles
- DATA_W, 2, width of each step's data value
- T_W, derived = DELAY_W + $clog2(NUM_STEPS) + 1, elapsed/target counter width (not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write step config
- cfg_idx  in  $clog2(NUM_STEPS)  step index written
- cfg_delay  in  DELAY_W  delay for step cfg_idx
- cfg_data  in  DATA_W  value applied when step fires
- start  in  1  begin a run (1-cycle request)
- mode  in  1  0=SEQ, 1=PAR; sampled with start
- abort  in  1  terminate the run
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at run completion
- step_fire  out  NUM_STEPS  1-cycle pulse per step on its fire edge
- fired  out  NUM_STEPS  sticky mask of steps fired this run
- out_data  out  NUM_STEPS*DATA_W  slot k at [k*DATA_W +: DATA_W]; holds the last applied value

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - Outputs: busy=0, done=0, step_fire=0, fired=0, out_data=0.
  - Internal state: state=IDLE, elapsed=0.
  - Config RAM (delay, data) clears to 0.
- States are IDLE, RUN, FIN.
- IDLE:
  - cfg_we writes delay[cfg_idx] and data[cfg_idx].
  - An out-of-range cfg_idx is ignored.
- Start:
  - start in IDLE at edge E0 does the following:
    - latches mode;
    - computes targets: SEQ gives t_k = sum(delay[0..k]), PAR gives t_k = delay[k];
    - clears elapsed and fired;
    - sets busy=1 and goes to RUN.
  - start in RUN or FIN is ignored.
  - cfg_we while busy is ignored, so config is frozen for the run.
- RUN:
  - elapsed increments by 1 every edge.
  - Step k fires at edge E0+t_k+1. On that edge: out_data slot k <= data[k], step_fire[k]=1 for one cycle, fired[k] set.
  - Delay 0 fires one cycle after start.
  - Multiple steps with equal t_k fire on the same edge.
  - In SEQ mode, t_k is strictly non-decreasing in k.
  - Targets are T_W wide. The SEQ sum cannot overflow.
- Completion:
  - The edge on which fired becomes all-ones moves the state to FIN.
  - In FIN: done=1 for one cycle and busy=0. The next edge returns to IDLE.
  - The back-to-back minimum is one start per (max t_k + 3) cycles.
- abort:
  - abort in RUN stops the run and goes to IDLE next edge with busy=0.
  - No done pulse is produced.
  - Slots that have not fired keep their prior values.
  - abort outside RUN is ignored.
- abort and the last fire on the same edge: abort wins. out_data still updates on that edge, but done is not pulsed.
- out_data is never cleared by start, only by rst. Each slot retains its value across runs, matching reg semantics.

Optional Feature:
- Macro: DELAY_STEP_SEQ_TSTAMP_EN.
- When defined:
  - Adds output step_time (NUM_STEPS*T_W).
  - On step k's fire edge, slot k captures elapsed+1, i.e. the cycle offset from start; equals t_k+1.
  - Reset value is 0.
  - Slots are not cleared by start.
- When undefined: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package delay_step_seq_pkg holds:
  - typedef mode_e {MODE_SEQ=0, MODE_PAR=1};
  - typedef state_e {IDLE, RUN, FIN};
  - function t_width(num_steps, delay_w).
- Sub-module delay_step_prefix_sum:
  - Combinational, parametrised by NUM_STEPS/DELAY_W.
  - Inputs: delay vector and mode.
  - Output: target vector of T_W-wide entries (prefix sums or pass-through).
  - The top module registers its output at start.

Test Plan:
- PAR, delays {0,5,10,20}, data {0,1,01,10}, start at E0:
  - step_fire[0..3] at E0+1, +6, +11, +21;
  - done at E0+22;
  - out_data = {10,01,1,0}.
- SEQ, same config: fires at E0+1, +6, +16, +36; done at E0+37.
- PAR, delays {3,3,3,7}: step_fire = 0111 on the single edge E0+4, then 1000 at E0+8.
- abort at E0+10 during SEQ run above:
  - fired=0011, no done, busy=0 at E0+11;
  - slots 2 and 3 keep prior values;
  - a start at E0+12 is accepted.
- rst pulse mid-run (E0+7, asynchronous, between edges): all outputs zero immediately; config cleared; a subsequent run with delays all 0 fires all steps at E0'+1.
- Ignore checks:
  - cfg_we and start while busy have no effect;
  - DELAY_STEP_SEQ_TSTAMP_EN defined: step_time = {21,11,6,1} after the PAR run.
